// File: rtl/barret_3779_pkg.sv
// rtl/barret_3779_pkg.sv - constants, S1 payload type and final correction for the mod-3779 Barrett reducer
package barret_3779_pkg;

  localparam int Q        = 3779;
  localparam int MU       = 4439;
  localparam int DIN_W    = 23;
  localparam int DOUT_W   = 12;
  localparam int QV_SHIFT = 11;
  localparam int T_SHIFT  = 13;

  // Derived widths: qv = din >> 11 fits 12 bits, qv*MU fits 25 bits, the
  // quotient estimate t fits 12 bits, and the raw remainder r < 3*Q fits 14 bits.
  localparam int QV_W     = DIN_W - QV_SHIFT;
  localparam int QH_W     = 25;
  localparam int T_W      = QH_W - T_SHIFT;
  localparam int R_W      = 14;

  // Sideband ID storage is sized for the largest supported requester count (8).
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [DIN_W-1:0]    din;
    logic [QH_W-1:0]     qh;
  } s1_payload_t;

  // The estimate t undershoots the true quotient by at most 2, so two
  // conditional subtractions always land in 0..Q-1.
  function automatic logic [DOUT_W-1:0] final_correct(input logic [R_W-1:0] r);
    logic [R_W-1:0] v;
    v = r;
    if (v >= R_W'(Q)) v = v - R_W'(Q);
    if (v >= R_W'(Q)) v = v - R_W'(Q);
    return v[DOUT_W-1:0];
  endfunction

endpackage

// File: rtl/barret_pipe_3779.sv
// rtl/barret_pipe_3779.sv - two-stage Barrett reducer mod 3779 with enable and valid/id sideband
module barret_pipe_3779
  import barret_3779_pkg::*;
#(
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [ID_W-1:0]   in_id,
  input  logic [DIN_W-1:0]  in_din,
  output logic              out_valid,
  output logic [ID_W-1:0]   out_id,
  output logic [DOUT_W-1:0] out_data
);

  s1_payload_t         s1;
  logic [QV_W-1:0]     qv;
  logic [QH_W-1:0]     qh_next;
  logic [T_W-1:0]      t;
  logic [DIN_W-1:0]    tq;
  logic [R_W-1:0]      r;
  logic [DOUT_W-1:0]   residue;
  logic                s2_valid;
  logic [ID_MAX_W-1:0] s2_id;
  logic [DOUT_W-1:0]   s2_data;

  assign qv      = in_din[DIN_W-1:QV_SHIFT];
  assign qh_next = QH_W'(qv) * QH_W'(MU);

  // t*Q never exceeds din, so the difference is non-negative and below 3*Q.
  assign t       = s1.qh[QH_W-1:T_SHIFT];
  assign tq      = DIN_W'(t) * DIN_W'(Q);
  assign r       = R_W'(s1.din - tq);
  assign residue = final_correct(r);

  // Stage 1: capture operand and the scaled quotient product; holds when en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else if (en) begin
      s1.valid <= in_valid;
      s1.id    <= ID_MAX_W'(in_id);
      s1.din   <= in_din;
      s1.qh    <= qh_next;
    end
  end

  // Stage 2: capture the corrected residue; these registers drive the response channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_data  <= '0;
    end else if (en) begin
      s2_valid <= s1.valid;
      s2_id    <= s1.id;
      s2_data  <= residue;
    end
  end

  assign out_valid = s2_valid;
  assign out_id    = ID_W'(s2_id);
  assign out_data  = s2_data;

endmodule

// File: rtl/barret_3779_arbiter.sv
// rtl/barret_3779_arbiter.sv - round-robin arbiter over one mod-3779 reducer; BARRET_ARB_FIXED_PRIO_EN selects fixed priority
module barret_3779_arbiter
  import barret_3779_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*DIN_W-1:0] req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DOUT_W-1:0]        rsp_data
);

  logic               adv;
  logic               accept;
  logic               found;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    sel;
  logic [DIN_W-1:0]   sel_din;

  // The whole pipeline moves only when the output slot is free or being drained.
  assign adv       = !(rsp_valid && !rsp_ready);
  assign req_ready = (adv && !rst) ? grant : '0;
  assign accept    = |req_ready;
  assign sel_din   = req_data[DIN_W*sel +: DIN_W];

`ifdef BARRET_ARB_FIXED_PRIO_EN

  // Fixed priority: lowest-indexed valid requester wins.
  always_comb begin
    grant = '0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        sel      = ID_W'(i);
      end
    end
  end

`else

  logic [ID_W-1:0] ptr;
  int              idx;

  // Round-robin: scan upward from ptr, wrapping at NUM_REQ, first valid wins.
  always_comb begin
    grant = '0;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        sel        = ID_W'(idx);
      end
    end
  end

  // Pointer moves past the requester just served; holds when nothing is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (sel == ID_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
    end
  end

`endif

  barret_pipe_3779 #(
    .ID_W (ID_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .en        (adv),
    .in_valid  (accept),
    .in_id     (sel),
    .in_din    (sel_din),
    .out_valid (rsp_valid),
    .out_id    (rsp_id),
    .out_data  (rsp_data)
  );

endmodule

// File: tb/tb_barret_3779_arbiter.sv
// tb/tb_barret_3779_arbiter.sv - self-checking bench for barret_3779_arbiter
module tb_barret_3779_arbiter;

  localparam int N  = 4;
  localparam int QM = 3779;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*23-1:0] req_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [11:0]     rsp_data;

  barret_3779_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int exp;
    int acc;
  } exp_t;

  typedef struct {
    int din;
    int exp;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   model_ptr = 0;
  bit   lat_exact = 0;
  exp_t sb[$];
  int   cons_ids[$];

  logic        s_rsp_valid;
  logic [11:0] s_rsp_data;
  logic [1:0]  s_rsp_id;
  logic [N-1:0] s_req_ready;
  logic [N-1:0] s_acc;
  bit          s_cons;
  bit          prev_stall = 0;
  logic [11:0] prev_data;
  logic [1:0]  prev_id;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (v[i]) return N'(1 << i);
    end
    return '0;
  endfunction

  task automatic set_req(input int i, input bit v, input int d);
    logic [22:0] d23;
    d23 = d[22:0];
    req_valid[i] = v;
    req_data[23*i +: 23] = d23;
  endtask

  // One clock: sample and score at the falling edge, then advance past the rising edge.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    int din;
    exp_t e;
    @(negedge clk);
    s_rsp_valid = rsp_valid;
    s_rsp_data  = rsp_data;
    s_rsp_id    = rsp_id;
    s_req_ready = req_ready;
    s_acc       = req_valid & req_ready;
    s_cons      = rsp_valid && rsp_ready;
    if (rst) begin
      sb.delete();
      model_ptr  = 0;
      prev_stall = 0;
    end else begin
      exp_rdy = (rsp_valid && !rsp_ready) ? '0 : model_grant(req_valid, model_ptr);
      chk("req_ready", int'(req_ready), int'(exp_rdy));
      if (prev_stall) begin
        chk("stall_hold_valid", int'(rsp_valid), 1);
        chk("stall_hold_data", int'(rsp_data), int'(prev_data));
        chk("stall_hold_id", int'(rsp_id), int'(prev_id));
      end
      if (s_cons) begin
        chk("rsp_has_request", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rsp_id", int'(rsp_id), e.id);
          chk("rsp_data", int'(rsp_data), e.exp);
          if (lat_exact) chk("latency", cyc + 1 - e.acc, 2);
        end
        cons_ids.push_back(int'(rsp_id));
      end
      for (int i = 0; i < N; i++) begin
        if (s_acc[i]) begin
          din = int'(req_data[23*i +: 23]);
          sb.push_back('{id: i, exp: din % QM, acc: cyc + 1});
`ifndef BARRET_ARB_FIXED_PRIO_EN
          model_ptr = (i + 1) % N;
`endif
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      prev_id    = rsp_id;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_acc(input int i);
    bit got;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      cycle();
      if (s_acc[i]) got = 1;
    end
    chk($sformatf("accept_wait_req%0d", i), int'(got), 1);
  endtask

  vec_t vecs[7];
  int   rem[N];
  bit   pend[N];
  int   gaps;
  bit   started;
  int   exp_id;
  int   d;

  initial begin
    vecs[0] = '{din: 0,       exp: 0};
    vecs[1] = '{din: 3778,    exp: 3778};
    vecs[2] = '{din: 3779,    exp: 0};
    vecs[3] = '{din: 7557,    exp: 3778};
    vecs[4] = '{din: 8388607, exp: 3006};
    vecs[5] = '{din: 11336,   exp: 3778};
    vecs[6] = '{din: 11337,   exp: 0};

    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_data = '0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("reset_rsp_valid", int'(s_rsp_valid), 0);
    chk("reset_rsp_data", int'(s_rsp_data), 0);
    chk("reset_rsp_id", int'(s_rsp_id), 0);
    chk("reset_req_ready", int'(s_req_ready), 0);

    // Single requester, table of operands, exact two-edge latency.
    lat_exact = 1;
    for (int v = 0; v < 7; v++) begin
      set_req(0, 1, vecs[v].din);
      wait_acc(0);
      set_req(0, 0, 0);
      cycle();
      chk("t1_s1_only_no_rsp", int'(s_rsp_valid), 0);
      cycle();
      chk("t1_rsp_valid", int'(s_rsp_valid), 1);
      chk("t1_rsp_data", int'(s_rsp_data), vecs[v].exp);
      chk("t1_rsp_id", int'(s_rsp_id), 0);
    end

    // All requesters busy: strict rotation, no gaps.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cons_ids.delete();
    for (int i = 0; i < N; i++) begin
      rem[i] = 8;
      set_req(i, 1, int'($urandom_range(0, 8388607)));
    end
    gaps = 0;
    started = 0;
    for (int c = 0; c < 300 && cons_ids.size() < 32; c++) begin
      cycle();
      if (started && !s_rsp_valid) gaps++;
      if (s_cons) started = 1;
      for (int i = 0; i < N; i++) begin
        if (s_acc[i]) begin
          rem[i]--;
          if (rem[i] > 0) set_req(i, 1, int'($urandom_range(0, 8388607)));
          else set_req(i, 0, 0);
        end
      end
    end
    chk("t2_rsp_count", cons_ids.size(), 32);
    chk("t2_gaps", gaps, 0);
    for (int k = 0; k < cons_ids.size(); k++) begin
`ifdef BARRET_ARB_FIXED_PRIO_EN
      exp_id = k / 8;
`else
      exp_id = k % 4;
`endif
      chk($sformatf("t2_id_seq_%0d", k), cons_ids[k], exp_id);
    end
    lat_exact = 0;

    // Pointer at 2 with requesters 1 and 3 pending.
    set_req(1, 1, 100);
    wait_acc(1);
    set_req(1, 0, 0);
    repeat (3) cycle();
    cons_ids.delete();
    set_req(1, 1, 200);
    set_req(3, 1, 300);
    cycle();
`ifdef BARRET_ARB_FIXED_PRIO_EN
    chk("t3_first_grant", int'(s_req_ready), 4'b0010);
    set_req(1, 0, 0);
    cycle();
    chk("t3_second_grant", int'(s_req_ready), 4'b1000);
    set_req(3, 0, 0);
`else
    chk("t3_first_grant", int'(s_req_ready), 4'b1000);
    set_req(3, 0, 0);
    cycle();
    chk("t3_second_grant", int'(s_req_ready), 4'b0010);
    set_req(1, 0, 0);
`endif
    repeat (4) cycle();
    chk("t3_rsp_count", cons_ids.size(), 2);
    if (cons_ids.size() == 2) begin
`ifdef BARRET_ARB_FIXED_PRIO_EN
      chk("t3_rsp_order0", cons_ids[0], 1);
      chk("t3_rsp_order1", cons_ids[1], 3);
`else
      chk("t3_rsp_order0", cons_ids[0], 3);
      chk("t3_rsp_order1", cons_ids[1], 1);
`endif
    end

    // Stall with a full pipeline: five frozen cycles, then ordered drain.
    rsp_ready = 1'b0;
    set_req(2, 1, 8388607);
    wait_acc(2);
    set_req(2, 1, 11336);
    cycle();
    chk("t4_second_accept", int'(s_acc), 4'b0100);
    set_req(2, 1, 7558);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t4_stall_ready", int'(s_req_ready), 0);
      chk("t4_stall_valid", int'(s_rsp_valid), 1);
      chk("t4_stall_data", int'(s_rsp_data), 3006);
      chk("t4_stall_id", int'(s_rsp_id), 2);
    end
    rsp_ready = 1'b1;
    cycle();
    chk("t4_accept_on_release", int'(s_acc), 4'b0100);
    chk("t4_out0", int'(s_rsp_data), 3006);
    set_req(2, 0, 0);
    cycle();
    chk("t4_out1_valid", int'(s_rsp_valid), 1);
    chk("t4_out1", int'(s_rsp_data), 3778);
    cycle();
    chk("t4_out2_valid", int'(s_rsp_valid), 1);
    chk("t4_out2", int'(s_rsp_data), 0);
    cycle();
    chk("t4_drained", int'(s_rsp_valid), 0);

    // Reset with two results in flight, then pointer restart.
    set_req(1, 1, 5000);
    wait_acc(1);
    set_req(1, 0, 0);
    set_req(2, 1, 6000);
    wait_acc(2);
    set_req(2, 0, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t5_no_rsp_after_rst", int'(s_rsp_valid), 0);
      chk("t5_no_ready_after_rst", int'(s_req_ready), 0);
    end
    set_req(0, 1, 1234);
    set_req(3, 1, 4321);
    cycle();
    chk("t5_ptr_restart", int'(s_req_ready), 4'b0001);
    set_req(0, 0, 0);
    wait_acc(3);
    set_req(3, 0, 0);
    repeat (4) cycle();

    // Random traffic against the scoreboard.
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 40) begin
          case ($urandom_range(0, 3))
            0: d = int'($urandom_range(0, 2218)) * QM + int'($urandom_range(0, 3778));
            1: d = 8388607 - int'($urandom_range(0, 64));
            2: d = int'($urandom_range(0, 11400));
            default: d = int'($urandom_range(0, 8388607));
          endcase
          set_req(i, 1, d);
          pend[i] = 1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
      for (int i = 0; i < N; i++) begin
        if (s_acc[i]) begin
          pend[i] = 0;
          set_req(i, 0, 0);
        end
      end
    end
    for (int i = 0; i < N; i++) set_req(i, 0, 0);
    rsp_ready = 1'b1;
    repeat (10) cycle();
    chk("random_all_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
